// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// synchronous flush and sticky overflow/underflow reporting.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  readAccept;
  logic                  writeAccept;

  // A read frees a slot in the same edge, so a full FIFO may still take a write.
  assign readAccept  = ren & ~empty & ~clr;
  assign writeAccept = wen & (~full | readAccept) & ~clr;

  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  always_ff @(posedge clk) begin
    if (writeAccept) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rvalid <= readAccept;
      if (writeAccept) wptr <= wptr + 1'b1;
      if (readAccept) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr];
      end
      case ({writeAccept, readAccept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wen && full && !readAccept) overflow <= 1'b1;
      if (ren && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a reference model predicts count, flags and
// error bits, and a queue of written data is compared against each read.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       wen;
  logic [7:0] wdata;
  logic       ren;
  logic [7:0] rdata;
  logic       rvalid;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int         assertCount = 0;
  int         failCount = 0;
  int         mCount;
  logic       mOvf;
  logic       mUnf;
  logic [7:0] mRdata;
  logic [7:0] sbQueue[$];

  sync_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AF_THRESH(12),
    .AE_THRESH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .wen(wen),
    .wdata(wdata),
    .ren(ren),
    .rdata(rdata),
    .rvalid(rvalid),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    sbQueue.delete();
    mCount = 0;
    mOvf   = 1'b0;
    mUnf   = 1'b0;
    mRdata = 8'h00;
  endtask

  task automatic checkStatus(input logic expRvalid);
    checkOutput("count", 32'(count), 32'(mCount));
    checkOutput("full", 32'(full), 32'(mCount == 16));
    checkOutput("empty", 32'(empty), 32'(mCount == 0));
    checkOutput("almost_full", 32'(almost_full), 32'(mCount >= 12));
    checkOutput("almost_empty", 32'(almost_empty), 32'(mCount <= 2));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
    checkOutput("underflow", 32'(underflow), 32'(mUnf));
    checkOutput("rvalid", 32'(rvalid), 32'(expRvalid));
    checkOutput("rdata", 32'(rdata), 32'(mRdata));
  endtask

  // One clock of stimulus; called just after a rising edge, checks after the next one.
  task automatic applyStimulus(input logic w, input logic [7:0] wd, input logic r, input logic c);
    logic rAcc;
    logic wAcc;
    rAcc = r && (mCount != 0) && !c;
    wAcc = w && ((mCount < 16) || rAcc) && !c;
    wen = w; wdata = wd; ren = r; clr = c;
    if (c) begin
      modelReset();
    end else begin
      if (r && mCount == 0) mUnf = 1'b1;
      if (w && mCount == 16 && !rAcc) mOvf = 1'b1;
      if (wAcc) sbQueue.push_back(wd);
      if (wAcc && !rAcc) mCount++;
      if (rAcc && !wAcc) mCount--;
    end
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; clr = 1'b0;
    if (rAcc) begin
      if (sbQueue.size() == 0) checkOutput("scoreboard_empty", 32'd1, 32'd0);
      else mRdata = sbQueue.pop_front();
    end
    checkStatus(rAcc);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkStatus(1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] fill and drain");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] simultaneous access at full");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] simultaneous access at empty");
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] pointer wrap-around");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 80; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 31) == 0));

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h67, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkStatus(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
